smmha_tcdm_responder: RTL
=========================

// Module: smmha_tcdm_responder
// PURPOSE
//  TCDM slave responder: the memory end of the accelerator's MP-port TCDM master interface.
//  Owns one single-ported word memory shared by MP ports.
//  Arbitrates requests round-robin, applies byte-enabled writes, returns read data after LAT cycles.
//  Used as the cluster-memory stand-in in block-level benches and FPGA smoke builds.
// PARAMETERS
//  MP        2            number of TCDM slave ports
//  NW        1024         memory depth in 32-bit words (power of 2)
//  LAT       1            read latency in cycles, grant cycle -> r_valid cycle; legal 1..4
//  BASE_ADDR 32'h1000_0000  byte address of word 0
// PORTS
//  clk_i         in   1         clock, all state on rising edge
//  rst_i         in   1         asynchronous reset, active-high
//  tcdm_req      in   MP        per-port request
//  tcdm_gnt      out  MP        per-port grant, combinational from req/stall/rr pointer
//  tcdm_add      in   MPx32     per-port byte address
//  tcdm_wen      in   MP        1 = read, 0 = write
//  tcdm_be       in   MPx4      per-port byte enables (writes only)
//  tcdm_data     in   MPx32     per-port write data
//  tcdm_r_data   out  MPx32     per-port read data, 0 when r_valid low
//  tcdm_r_valid  out  MP        per-port read response strobe, one cycle per granted read
//  stall_i       in   1         1 = grant nothing this cycle (bench back-pressure)
//  err_o         out  1         sticky out-of-range access flag
// BEHAVIOUR
//  Reset: gnt/r_valid/r_data/err_o = 0; rr pointer = 0; latency pipe emptied.
//   In-flight reads are dropped and never answered.
//  Memory contents are not reset.
//  Arbitration:
//   - at most one grant per cycle; none while stall_i = 1
//   - search starts at rr pointer, wraps modulo MP
//   - first requesting port is granted
//   - on a grant, the pointer moves to granted index + 1 (mod MP); otherwise it holds
//   - gnt is asserted in the same cycle as req
//   - an ungranted port keeps req and its payload stable until granted; the block never checks this
//  Addressing:
//   - off = add - BASE_ADDR
//   - in range when off[31:2] < NW; word index = off[2+log2(NW)-1:2]
//   - add[1:0] is ignored
//  Write (wen = 0):
//   - at the grant edge, only the bytes with be[i] = 1 are updated
//   - produces no response
//   - be = 0 is a legal no-op
//  Read (wen = 1):
//   - the memory is sampled at the grant edge
//   - the word is returned exactly LAT cycles after the grant cycle, on the granted port only
//   - the LAT-deep pipe carries {valid, port, data}
//   - one response per cycle at most, because there is one grant per cycle
//   - a different port can be granted every cycle; this is full throughput
//  Ordering:
//   - a write granted in cycle t is visible to a read granted in cycle t+1 or later
//   - read and write in the same cycle cannot happen (single grant)
//  Out of range:
//   - the request is still granted
//   - a write is dropped
//   - a read returns 32'hDEAD_BEEF with normal latency
//   - err_o is set the cycle after the grant and holds until reset
//  Reset asserted mid-transfer: the same requirements as the reset entry above apply immediately (asynchronous); gnt = 0 while rst_i = 1.
// TESTING
//  T1 basic, LAT = 1:
//   - port0 writes 32'hA5A5_0001 to BASE + 0x10, be = F; next cycle port0 reads BASE + 0x10
//   - -> r_valid[0] 1 cycle after the read grant, r_data = 32'hA5A5_0001
//  T2 byte enables:
//   - write 32'h1122_3344 (be = F), then 32'hFFFF_FFFF (be = 4'b0101), then read
//   - -> 32'h11FF_33FF
//  T3 round-robin, MP = 2:
//   - both ports hold req (reads) for 6 cycles
//   - -> gnt alternates 01,10,01,10,01,10; each port receives 3 r_valid, in order
//  T4 stall:
//   - stall_i = 1 for 3 cycles with both req high -> gnt = 0 for those cycles
//   - after release, port at rr pointer is granted first; no spurious r_valid during stall
//  T5 out of range:
//   - read BASE + 4*NW -> r_data = 32'hDEAD_BEEF, err_o = 1 and sticky
//   - write to the same address leaves memory unchanged (re-read word 0 intact)
//  T6 reset mid-read, LAT = 3:
//   - assert rst_i 1 cycle after a read grant -> no r_valid for that read, err_o = 0, rr = 0
//   - memory retains previously written data

Source files
------------

// File: rtl/smmha_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module      : smmha_tcdm_responder
// Description : TCDM slave responder. One single-ported 32-bit word memory is
//               shared by MP request ports. A round-robin arbiter grants at
//               most one port per cycle. Writes apply their byte enables at
//               the grant edge. Reads sample the memory at the grant edge and
//               return the word on the granted port exactly LAT cycles later.
//               Accesses outside the memory window are still granted: such a
//               write is dropped, such a read returns 32'hDEAD_BEEF, and
//               err_o is set sticky.
// Ports       : clk_i        - clock, all state on rising edge
//               rst_i        - asynchronous reset, active-high
//               tcdm_req     - per-port request
//               tcdm_gnt     - per-port grant (combinational)
//               tcdm_add     - per-port byte address
//               tcdm_wen     - per-port 1 = read, 0 = write
//               tcdm_be      - per-port byte enables (writes only)
//               tcdm_data    - per-port write data
//               tcdm_r_data  - per-port read data, 0 when r_valid is low
//               tcdm_r_valid - per-port read response strobe
//               stall_i      - suppresses all grants this cycle
//               err_o        - sticky out-of-range access flag
// Revision    : 1.0 - initial release
// ============================================================================
module smmha_tcdm_responder #(
    parameter int unsigned MP        = 2,
    parameter int unsigned NW        = 1024,
    parameter int unsigned LAT       = 1,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MP-1:0]        tcdm_req,
    output logic [MP-1:0]        tcdm_gnt,
    input  logic [MP-1:0][31:0]  tcdm_add,
    input  logic [MP-1:0]        tcdm_wen,
    input  logic [MP-1:0][3:0]   tcdm_be,
    input  logic [MP-1:0][31:0]  tcdm_data,
    output logic [MP-1:0][31:0]  tcdm_r_data,
    output logic [MP-1:0]        tcdm_r_valid,
    input  logic                 stall_i,
    output logic                 err_o
);

    // Port index width; a single-port build still needs a 1-bit index.
    localparam int unsigned      c_PW        = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned      c_AW        = $clog2(NW);
    localparam logic [c_PW-1:0]  c_LAST_PORT = c_PW'(MP - 1);
    localparam logic [29:0]      c_NW_WORDS  = 30'(NW);
    localparam logic [31:0]      c_OOR_DATA  = 32'hDEAD_BEEF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]                r_mem [NW];
    logic [c_PW-1:0]            r_rr;
    logic                       r_err;
    // Read response pipe: stage 0 is loaded at the grant edge, stage LAT-1
    // drives the response ports.
    logic [LAT-1:0]             r_pv;
    logic [LAT-1:0][c_PW-1:0]   r_pp;
    logic [LAT-1:0][31:0]       r_pd;

    // ------------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------------
    logic                       w_found;
    logic [c_PW-1:0]            w_sel;
    logic [c_PW-1:0]            w_idx;
    logic                       w_grant;

    // Walk the ports starting at the rr pointer, wrapping modulo MP; the
    // first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = r_rr;
        for (int i = 0; i < MP; i++) begin
            if (!w_found && tcdm_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
            w_idx = (w_idx == c_LAST_PORT) ? '0 : w_idx + 1'b1;
        end
    end

    // Reset is folded in so that grants drop as soon as rst_i rises, and so
    // that the memory (which has no reset) cannot be written during reset.
    assign w_grant = w_found & ~stall_i & ~rst_i;

    always_comb begin
        tcdm_gnt = '0;
        if (w_grant) begin
            tcdm_gnt[w_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Granted request payload and address decode
    // ------------------------------------------------------------------------
    logic [31:0]                w_add;
    logic                       w_wen;
    logic [3:0]                 w_be;
    logic [31:0]                w_wdata;
    logic [31:0]                w_off;
    logic                       w_in_range;
    logic [c_AW-1:0]            w_word;
    logic [31:0]                w_rdata;
    logic                       w_unused_off;

    assign w_add   = tcdm_add[w_sel];
    assign w_wen   = tcdm_wen[w_sel];
    assign w_be    = tcdm_be[w_sel];
    assign w_wdata = tcdm_data[w_sel];

    // Addresses below BASE_ADDR wrap to a huge offset and land out of range.
    assign w_off        = w_add - BASE_ADDR;
    assign w_in_range   = (w_off[31:2] < c_NW_WORDS);
    assign w_word       = w_off[c_AW+1:2];
    // Byte offset within the word plays no part in word addressing.
    assign w_unused_off = ^w_off[1:0];

    assign w_rdata = w_in_range ? r_mem[w_word] : c_OOR_DATA;

    // ------------------------------------------------------------------------
    // Memory array (contents survive reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_grant && !w_wen && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_word][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pointer, error flag and read response pipe
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr  <= '0;
            r_err <= 1'b0;
            r_pv  <= '0;
            r_pp  <= '0;
            r_pd  <= '0;
        end else begin
            if (w_grant) begin
                r_rr <= (w_sel == c_LAST_PORT) ? '0 : w_sel + 1'b1;
                if (!w_in_range) begin
                    r_err <= 1'b1;
                end
            end
            r_pv[0] <= w_grant & w_wen;
            r_pp[0] <= w_sel;
            r_pd[0] <= w_rdata;
            for (int s = 1; s < LAT; s++) begin
                r_pv[s] <= r_pv[s-1];
                r_pp[s] <= r_pp[s-1];
                r_pd[s] <= r_pd[s-1];
            end
        end
    end

    assign err_o = r_err;

    // ------------------------------------------------------------------------
    // Response steering: only the port that issued the read sees it.
    // ------------------------------------------------------------------------
    for (genvar gp = 0; gp < MP; gp++) begin : g_resp
        logic w_hit;
        assign w_hit             = r_pv[LAT-1] && (r_pp[LAT-1] == c_PW'(gp));
        assign tcdm_r_valid[gp]  = w_hit;
        assign tcdm_r_data[gp]   = w_hit ? r_pd[LAT-1] : 32'h0;
    end

endmodule
`default_nettype wire
